// File: rtl/snn_idx_pkg.sv
// snn_idx_pkg: shared widths, token field positions and FSM state type for the index codec
package snn_idx_pkg;
    localparam int W        = 8;
    localparam int IW       = $clog2(W);
    localparam int LAST_BIT = IW;
    typedef enum logic {IDLE, ACCUM} idx_state_t;
endpackage

// File: rtl/idx_dec_obuf.sv
// idx_dec_obuf: single-entry output register that holds under backpressure and reloads without a bubble
module idx_dec_obuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         opt_ready,
    output logic         opt_valid,
    output logic [W-1:0] sparse_bits
);
    always_ff @(posedge clk) begin
        if (rst) begin
            opt_valid   <= 1'b0;
            sparse_bits <= '0;
        end else begin
            opt_valid <= load || (opt_valid && !opt_ready);
            if (load) sparse_bits <= din;
        end
    end
endmodule

// File: rtl/idx_dec.sv
// idx_dec: rebuilds a sparse bit vector from a stream of ascending index tokens, flagging ordering errors
module idx_dec #(
    parameter int W  = snn_idx_pkg::W,
    parameter int IW = snn_idx_pkg::IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ipt_valid,
    input  logic [IW:0]   enc,
    input  logic          ipt_null,
    output logic          ipt_ready,
    output logic [W-1:0]  sparse_bits,
    output logic          opt_valid,
    input  logic          opt_ready,
    output logic          err
);
    import snn_idx_pkg::*;
    idx_state_t    state, state_nxt;
    logic [W-1:0]  acc, onehot;
    logic [IW-1:0] idx, prev_idx;
    logic          last, take, bad;
    assign idx       = enc[IW-1:0];
    assign last      = enc[IW] || ipt_null;
    assign ipt_ready = !opt_valid || opt_ready;
    assign take      = ipt_valid && ipt_ready;
    assign onehot    = ipt_null ? '0 : (W'(1) << idx);
    // a null token always closes the vector; it is an error if unmarked or if it lands mid-vector
    always_comb begin
        state_nxt = state;
        bad       = 1'b0;
        if (take) begin
            state_nxt = last ? IDLE : ACCUM;
            bad = (ipt_null && !enc[IW]) || (state == ACCUM && (ipt_null || idx <= prev_idx));
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            prev_idx <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= bad;
            if (take) begin
                acc <= last ? '0 : (acc | onehot);
                if (!ipt_null) prev_idx <= idx;
            end
        end
    end
    idx_dec_obuf #(.W(W)) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .load        (take && last),
        .din         (acc | onehot),
        .opt_ready   (opt_ready),
        .opt_valid   (opt_valid),
        .sparse_bits (sparse_bits)
    );
endmodule

// File: tb/tb_idx_dec.sv
// tb_idx_dec: scoreboard bench for idx_dec with directed cases and a random encoder loopback
module tb_idx_dec;
    import snn_idx_pkg::*;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ipt_valid = 1'b0;
    logic [IW:0]   enc = '0;
    logic          ipt_null = 1'b0;
    logic          ipt_ready;
    logic [W-1:0]  sparse_bits;
    logic          opt_valid;
    logic          opt_ready = 1'b1;
    logic          err;
    int            checks = 0;
    int            failures = 0;
    int            err_cnt = 0;
    bit            rnd = 1'b0;
    logic [W-1:0]  m_acc = '0;
    logic [W-1:0]  expq[$];

    idx_dec dut (
        .clk(clk), .rst(rst), .ipt_valid(ipt_valid), .enc(enc), .ipt_null(ipt_null),
        .ipt_ready(ipt_ready), .sparse_bits(sparse_bits), .opt_valid(opt_valid),
        .opt_ready(opt_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference encoder-side model: one-hot accumulate, emit on last
    task automatic model(input logic l, input logic [IW-1:0] i, input logic n);
        logic [W-1:0] oh;
        oh = n ? '0 : (W'(1) << i);
        if (l || n) begin
            expq.push_back(m_acc | oh);
            m_acc = '0;
        end else m_acc = m_acc | oh;
    endtask

    // called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic l, input logic [IW-1:0] i, input logic n);
        int t = 0;
        ipt_valid = 1'b1;
        enc = {l, i};
        ipt_null = n;
        if (rnd) opt_ready = 1'($urandom_range(0, 1));
        #1;
        while (!ipt_ready && t < 50) begin
            @(posedge clk); #1;
            if (rnd) opt_ready = 1'($urandom_range(0, 1));
            #1;
            t++;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 0);
        model(l, i, n);
        @(posedge clk); #1;
        ipt_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (!rst && opt_valid && opt_ready) begin
            if (expq.size() == 0) chk("unexpected_out", 32'(sparse_bits), 32'hdead);
            else chk("out_data", 32'(sparse_bits), 32'(expq.pop_front()));
        end
    end

    initial begin
        int err_base;
        logic [W-1:0] v;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(opt_valid), 0);
        chk("rst_bits", 32'(sparse_bits), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(ipt_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(0, 2, 0); send(0, 5, 0); send(1, 7, 0);
        chk("a4_valid", 32'(opt_valid), 1);
        chk("a4_bits", 32'(sparse_bits), 32'ha4);
        chk("a4_err", 32'(err), 0);
        @(posedge clk); #1;

        send(1, 0, 1);
        chk("null_valid", 32'(opt_valid), 1);
        chk("null_bits", 32'(sparse_bits), 0);
        chk("null_err", 32'(err), 0);
        @(posedge clk); #1;

        opt_ready = 1'b0;
        send(1, 0, 0);
        ipt_valid = 1'b1; enc = {1'b1, 3'(3)}; ipt_null = 1'b0;
        #1;
        chk("bp_ready", 32'(ipt_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_hold_valid", 32'(opt_valid), 1);
        chk("bp_hold_bits", 32'(sparse_bits), 32'h01);
        opt_ready = 1'b1;
        model(1, 3, 0);
        @(posedge clk); #1;
        ipt_valid = 1'b0;
        chk("nobubble_valid", 32'(opt_valid), 1);
        chk("reload_bits", 32'(sparse_bits), 32'h08);
        @(posedge clk); #1;
        chk("drain_valid", 32'(opt_valid), 0);

        send(0, 4, 0); send(1, 4, 0);
        chk("order_err", 32'(err), 1);
        chk("order_bits", 32'(sparse_bits), 32'h10);
        @(posedge clk); #1;
        chk("order_err_pulse", 32'(err), 0);

        send(0, 6, 0);
        rst = 1'b1;
        m_acc = '0;
        ipt_valid = 1'b1; enc = {1'b1, 3'(5)}; ipt_null = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ready", 32'(ipt_ready), 1);
        @(posedge clk); #1;
        ipt_valid = 1'b0; rst = 1'b0;
        chk("rst_mid_valid", 32'(opt_valid), 0);
        send(1, 1, 0);
        chk("rst_mid_bits", 32'(sparse_bits), 32'h02);
        @(posedge clk); #1;

        err_base = err_cnt;
        rnd = 1'b1;
        for (int n = 0; n < 100; n++) begin
            v = W'($urandom);
            if (n % 10 == 0) v = '0;
            if (v == '0) send(1, 0, 1);
            else for (int b = 0; b < W; b++)
                if (v[b]) send((v >> (b + 1)) == '0, IW'(b), 0);
        end
        rnd = 1'b0;
        opt_ready = 1'b1;
        for (int t = 0; t < 20 && expq.size() > 0; t++) @(posedge clk);
        #1;
        chk("loop_drained", 32'(expq.size()), 0);
        chk("loop_no_err", 32'(err_cnt), 32'(err_base));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
